// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/load-store memory arbiter.
package mem_arb_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 32;
  localparam int DEPTH_DEF     = 32;
  localparam int MAX_BURST_DEF = 4;

  // IDLE: nothing granted last cycle; OWN_x: last grant went to x.
  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_t;

  // Burst counter must hold 0..max_burst inclusive.
  function automatic int cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/mem_arb_fsm.sv
// Round-robin owner tracking with a burst limit; produces the grants.
module mem_arb_fsm
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic d_req,
  output logic i_gnt,
  output logic d_gnt
);

  localparam int CNT_W = cnt_w(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pick_i, pick_d;

  // Owner and burst count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Grant decision and owner/count update.
  always_comb begin
    pick_i    = 1'b0;
    pick_d    = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    if (i_req && d_req) begin
      case (state)
        OWN_D:   if (cnt < CNT_MAX) pick_d = 1'b1; else pick_i = 1'b1;
        OWN_I:   if (cnt < CNT_MAX) pick_i = 1'b1; else pick_d = 1'b1;
        default: pick_d = 1'b1;  // data wins a tie from IDLE
      endcase
    end else begin
      pick_i = i_req;
      pick_d = d_req;
    end

    if (pick_d) begin
      if (state == OWN_D) begin
        cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
      end else begin
        state_nxt = OWN_D;
        cnt_nxt   = CNT_W'(1);
      end
    end else if (pick_i) begin
      if (state == OWN_I) begin
        cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
      end else begin
        state_nxt = OWN_I;
        cnt_nxt   = CNT_W'(1);
      end
    end else begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end

    // Grants are suppressed while reset is held.
    i_gnt = rst & pick_i;
    d_gnt = rst & pick_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between fetch and load/store with a
// registered one-cycle response path and an out-of-range error response.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_dout
);

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  logic i_in_range, d_in_range;

  mem_arb_fsm #(.MAX_BURST(MAX_BURST)) u_fsm (
    .clk   (clk),
    .rst   (rst),
    .i_req (i_req),
    .d_req (d_req),
    .i_gnt (i_gnt),
    .d_gnt (d_gnt)
  );

  // Range check and memory port mux; idle bus is driven to zero.
  always_comb begin
    i_in_range = {1'b0, i_addr} < DEPTH_X;
    d_in_range = {1'b0, d_addr} < DEPTH_X;
    mem_addr   = '0;
    mem_din    = '0;
    if (d_gnt) begin
      mem_addr = d_addr;
      mem_din  = d_wdata;
    end else if (i_gnt) begin
      mem_addr = i_addr;
    end
    mem_wen = d_gnt & d_we & d_in_range;
  end

  // Response registers; rdata is zero for writes, errors and idle cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rvalid <= 1'b0;
      i_err    <= 1'b0;
      i_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= '0;
    end else begin
      i_rvalid <= i_gnt;
      i_err    <= i_gnt & ~i_in_range;
      i_rdata  <= (i_gnt & i_in_range) ? mem_dout : '0;
      d_rvalid <= d_gnt;
      d_err    <= d_gnt & ~d_in_range;
      d_rdata  <= (d_gnt & ~d_we & d_in_range) ? mem_dout : '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a behavioural memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, mem_wen;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_din, mem_dout;

  logic [31:0] ram [0:31];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen), .mem_dout(mem_dout)
  );

  // Memory model: combinational read, write at the rising edge.
  assign mem_dout = (mem_addr < 32) ? ram[mem_addr[4:0]] : 32'h0;
  always @(posedge clk) if (mem_wen) ram[mem_addr[4:0]] <= mem_din;

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        xig;    // expected i_gnt
    logic        xdg;    // expected d_gnt
    logic [31:0] xma;    // expected mem_addr
    logic        xwen;   // expected mem_wen
    logic [31:0] xdin;   // expected mem_din
    logic        xiv;    // response visible this cycle (from previous grant)
    logic [31:0] xird;
    logic        xie;
    logic        xdv;
    logic [31:0] xdrd;
    logic        xde;
  } vec_t;

  vec_t v [0:20];

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic we, input logic [31:0] da, input logic [31:0] dw);
    i_req = ir; i_addr = ia; d_req = dr; d_we = we; d_addr = da; d_wdata = dw;
  endtask

  initial begin
    logic [11:0] gseq;
    logic        dg, pdg;
    for (int i = 0; i < 32; i++) ram[i] = 32'hA000_0000 + i;
    ram[5] = 32'hDEAD_BEEF;

    // Directed sequence from IDLE; response fields are what the previous row produced.
    //           ireq iaddr dreq we daddr  wdata         ig dg maddr  wen din           iv ird           ie dv drd           de
    v[0] = '{1, 5,  0, 0, 0,  0,            1, 0, 5,  0, 0,            0, 0,            0, 0, 0,            0};
    v[1] = '{0, 0,  0, 0, 0,  0,            0, 0, 0,  0, 0,            1, 32'hDEADBEEF, 0, 0, 0,            0};
    v[2] = '{0, 0,  1, 1, 3,  32'h12345678, 0, 1, 3,  1, 32'h12345678, 0, 0,            0, 0, 0,            0};
    v[3] = '{1, 3,  0, 0, 0,  0,            1, 0, 3,  0, 0,            0, 0,            0, 1, 0,            0};
    v[4] = '{0, 0,  1, 1, 32, 32'hFFFFFFFF, 0, 1, 32, 0, 32'hFFFFFFFF, 1, 32'h12345678, 0, 0, 0,            0};
    v[5] = '{0, 0,  1, 0, 0,  0,            0, 1, 0,  0, 0,            0, 0,            0, 1, 0,            1};
    v[6] = '{1, 40, 0, 0, 0,  0,            1, 0, 40, 0, 0,            0, 0,            0, 1, 32'hA0000000, 0};
    v[7] = '{0, 0,  0, 0, 0,  0,            0, 0, 0,  0, 0,            1, 0,            1, 0, 0,            0};
    // Sustained contention from IDLE: D,D,D,D,I,I,I,I,D,D,D,D.
    gseq = 12'b1111_0000_1111;
    pdg  = 1'bx;
    for (int k = 0; k < 12; k++) begin
      dg = gseq[k];
      v[8+k] = '{1, 1, 1, 0, 2, 32'h55, ~dg, dg, dg ? 32'd2 : 32'd1, 0, dg ? 32'h55 : 32'h0,
                 (k > 0) && !pdg, ((k > 0) && !pdg) ? 32'hA0000001 : 32'h0, 0,
                 (k > 0) && pdg,  ((k > 0) && pdg)  ? 32'hA0000002 : 32'h0, 0};
      pdg = dg;
    end
    v[20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA0000002, 0};

    // Reset held with both requests asserted.
    rst = 1'b0;
    drive(1, 5, 1, 1, 3, 32'hCAFE);
    repeat (2) @(negedge clk);
    chk("rst_gnt",  {i_gnt, d_gnt, mem_wen}, 3'b000);
    chk("rst_irsp", {i_rvalid, i_err, i_rdata}, 34'h0);
    chk("rst_drsp", {d_rvalid, d_err, d_rdata}, 34'h0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_mem",  {mem_addr, mem_din}, 64'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_gnt", {i_gnt, d_gnt, mem_wen}, 3'b000);

    for (int k = 0; k <= 20; k++) begin
      @(posedge clk); #1;
      drive(v[k].ireq, v[k].iaddr, v[k].dreq, v[k].dwe, v[k].daddr, v[k].dwdata);
      @(negedge clk);
      chk($sformatf("gnt[%0d]", k),  {i_gnt, d_gnt}, {v[k].xig, v[k].xdg});
      chk($sformatf("mem[%0d]", k),  {mem_addr, mem_din, mem_wen}, {v[k].xma, v[k].xdin, v[k].xwen});
      chk($sformatf("irsp[%0d]", k), {i_rvalid, i_err, i_rdata}, {v[k].xiv, v[k].xie, v[k].xird});
      chk($sformatf("drsp[%0d]", k), {d_rvalid, d_err, d_rdata}, {v[k].xdv, v[k].xde, v[k].xdrd});
    end
    chk("ram0_kept", ram[0], 32'hA0000000);
    chk("ram3_new",  ram[3], 32'h12345678);

    // Reset in the cycle after a fetch grant drops the response and clears ownership.
    @(posedge clk); #1;
    drive(1, 5, 0, 0, 0, 0);
    @(negedge clk);
    chk("mid_igrant", {i_gnt, d_gnt}, 2'b10);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 5, 1, 0, 2, 0);
    @(negedge clk);
    chk("mid_rvalid", {i_rvalid, d_rvalid}, 2'b00);
    chk("mid_gnt",    {i_gnt, d_gnt, mem_wen}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b1;
    // Fresh IDLE with cnt=0: four data grants, then fetch.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst[%0d]", k), {i_gnt, d_gnt}, (k < 4) ? 2'b01 : 2'b10);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-ported unified instruction/data memory between the instruction-fetch requester and the load/store requester. It grants at most one access per cycle, drives the memory's address, write-data and write-enable inputs, and returns registered read data with a fixed one-cycle latency. Round-robin with a burst limit prevents starvation. Out-of-range addresses are rejected with an error response.

## Interface
- `DATA_W`, 32: data width.
- `ADDR_W`, 32: address width; addresses are word indices.
- `DEPTH`, 32: number of memory words; valid addresses are 0..DEPTH-1.
- `MAX_BURST`, 4: maximum consecutive grants to one requester while the other is waiting; must be ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i_req` in 1: fetch request.
- `i_addr` in ADDR_W: fetch word address.
- `i_gnt` out 1: fetch accepted this cycle.
- `i_rvalid` out 1: fetch response valid, one-cycle pulse.
- `i_rdata` out DATA_W: fetch read data.
- `i_err` out 1: fetch address out of range; qualified by `i_rvalid`.
- `d_req` in 1: data request.
- `d_we` in 1: data write (1) or read (0).
- `d_addr` in ADDR_W: data word address.
- `d_wdata` in DATA_W: store data.
- `d_gnt` out 1: data request accepted this cycle.
- `d_rvalid` out 1: data response valid for every accepted read or write.
- `d_rdata` out DATA_W: load data; 0 for writes and errors.
- `d_err` out 1: data address out of range; qualified by `d_rvalid`.
- `mem_addr` out ADDR_W: to memory address.
- `mem_din` out DATA_W: to memory write data.
- `mem_wen` out 1: to memory write enable.
- `mem_dout` in DATA_W: from memory; combinational read of `mem_addr`.

## Operation
- **FSM states:**
  - IDLE: no previous grant.
  - OWN_I: last grant went to fetch.
  - OWN_D: last grant went to data.
- **Burst counter:** `cnt` counts consecutive grants to the current owner. It saturates at MAX_BURST.
- **Grant rules**, evaluated combinationally each cycle:
  - Neither request: no grant; next state IDLE; `cnt`=0.
  - Exactly one request: that requester is granted.
  - Both requests, state IDLE: data is granted.
  - Both requests, owner with `cnt` < MAX_BURST: owner is granted again.
  - Both requests, owner with `cnt` = MAX_BURST: the other requester is granted.
- **State update on a grant:**
  - Grant to the same owner: `cnt`+1, saturating.
  - Grant to a different requester: state switches to that owner; `cnt`=1.
- **Memory drive:**
  - Granted requester's address goes to `mem_addr`.
  - `mem_din` = `d_wdata` when data is granted, else 0.
  - `mem_wen` = `d_gnt & d_we & in_range`.
  - With no grant: `mem_addr`=0, `mem_din`=0, `mem_wen`=0.
- **Range check:** `in_range` = addr < DEPTH. An out-of-range request is still granted. No write occurs. The response carries err=1 and rdata=0.
- **Response:** at the edge ending the grant cycle, register `mem_dout` (or 0 for a write or error), err, and rvalid for the granted port. The other port's rvalid is 0.
- **Request rules:**
  - A requester holds req, addr, we and wdata stable until it sees gnt.
  - Dropping req before gnt is legal and discards the request.
  - Responses are always consumed; there is no response backpressure.
- **Reset:** while `rst`=0, both gnt outputs and `mem_wen` are forced to 0 regardless of requests.

## Timing
- Reset values:
  - State IDLE, `cnt`=0.
  - `i_rvalid`, `d_rvalid`, `i_err`, `d_err` all 0.
  - `i_rdata`, `d_rdata` both 0.
  - `i_gnt`, `d_gnt`, `mem_wen` 0; `mem_addr`, `mem_din` 0.
- Gnt is combinational from req and registered state, in the same cycle as req (zero wait when uncontended).
- Read latency: rvalid and rdata are valid exactly 1 cycle after gnt.
- Throughput: one access per cycle, back-to-back grants allowed.
- Write latency: memory updated at the edge ending the `d_gnt` cycle. A read of the same address granted in the next cycle returns the new data.
- With continuous contention, no requester waits more than MAX_BURST cycles.
- Reset asserted mid-operation: any response pending for the next cycle is dropped (rvalid stays 0). No write occurs in a cycle where `rst`=0.

## Structure
- Package `mem_arb_pkg`:
  - State enum typedef: IDLE, OWN_I, OWN_D.
  - Default parameter constants.
  - `cnt` width: $clog2(MAX_BURST+1).
- Sub-module `mem_arb_fsm`: state register, `cnt`, and grant decision. Inputs: `i_req`, `d_req`. Outputs: `i_gnt`, `d_gnt`.
- Top level `mem_arbiter`: range check, memory mux, response registers.

## Test plan
- **Reset:** hold `rst`=0 with `i_req`=`d_req`=1 → all outputs 0, `mem_wen` 0. Release with no requests → state IDLE, no grants.
- **Single fetch:** ram[5]=0xDEADBEEF; `i_req`=1, `i_addr`=5 → `i_gnt` the same cycle. Next cycle `i_rvalid`=1, `i_rdata`=0xDEADBEEF, `i_err`=0.
- **Contention:** MAX_BURST=4; `i_req` and `d_req` held high from IDLE for 12 cycles → grant sequence D,D,D,D,I,I,I,I,D,D,D,D.
- **Write then read:** data write addr 3, data 0x12345678 → `d_rvalid` next cycle with `d_rdata`=0. Fetch of addr 3 in the following cycle → `i_rdata`=0x12345678.
- **Out-of-range write:** `d_we`=1, addr 32 (DEPTH=32), data 0xFFFFFFFF → `d_gnt`=1, `mem_wen`=0. Next cycle `d_rvalid`=1, `d_err`=1, `d_rdata`=0. ram[0] is unchanged.
- **Reset mid-operation:** assert `rst`=0 in the cycle right after a fetch grant → `i_rvalid` stays 0. State returns to IDLE and `cnt` to 0.
